ebus_dev_responder: RTL and testbench

Device-side EBUS responder: the far end of the EBUS transactions that the EDP slices drive and sample. It decodes controller select and function, and completes the demand/transfer handshake for CONO, CONI, DATAO and DATAI. It holds the device's 18-bit conditions register and 36-bit data register, and hands strobes to the local device logic. It sits beside each EBUS device (diagnostic targets, console interface) and synchronizes the asynchronous bus strobes into the device clock.

---
 rtl/ebus_dev_responder.sv | 82 ++++++++
 tb/tb_ebus_dev_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_dev_responder.sv
// ebus_dev_responder: EBUS device-side CONO/CONI/DATAO/DATAI responder; demand sync in, xfer/oe/data out, cono/data registers and strobes to local logic (bus bit 0 = index 35)
module ebus_dev_responder #(
  parameter logic [6:0] DEV_CODE = 7'o0
) (
  input  logic        clk_h,
  input  logic        mr_reset_h,
  input  logic [6:0]  ebus_cs_h,
  input  logic [2:0]  ebus_func_h,
  input  logic        ebus_demand_h,
  input  logic [35:0] ebus_d_in_h,
  output logic [35:0] ebus_d_out_h,
  output logic        ebus_d_oe_h,
  output logic        ebus_xfer_h,
  input  logic [17:0] dev_status_h,
  input  logic        dev_load_h,
  input  logic [35:0] dev_load_data_h,
  output logic [17:0] dev_cono_h,
  output logic [35:0] dev_data_h,
  output logic        dev_cono_pulse_h,
  output logic        dev_datao_pulse_h,
  output logic        dev_datai_pulse_h
);
  typedef enum logic [2:0] {IDLE, WRITE, RDSETUP, XFER, DROP} state_t;
  state_t state, next;
  logic dmd_m, dmd_s, dmd_s_d;
  logic [1:0] func_r;
  logic [35:0] din_r;
  logic dmd_rise, hit, go, done;
  assign dmd_rise = dmd_s & ~dmd_s_d;
  assign hit = (ebus_cs_h == DEV_CODE) & ~ebus_func_h[2];
  assign go = (state == IDLE) & dmd_rise & hit;
  assign done = (state == XFER) & ~dmd_s;
  always_comb begin
    next = state;
    ebus_xfer_h = state == XFER;
    case (state)
      IDLE:          next = go ? (ebus_func_h[0] ? RDSETUP : WRITE) : IDLE;
      WRITE, RDSETUP: next = XFER;
      XFER:          next = dmd_s ? XFER : DROP;
      default:       next = IDLE;
    endcase
  end
  always_ff @(posedge clk_h or posedge mr_reset_h) begin
    if (mr_reset_h) begin
      state <= IDLE;
      dmd_m <= 1'b0;
      dmd_s <= 1'b0;
      dmd_s_d <= 1'b0;
      func_r <= 2'd0;
      din_r <= '0;
      ebus_d_out_h <= '0;
      ebus_d_oe_h <= 1'b0;
      dev_cono_h <= '0;
      dev_data_h <= '0;
      dev_cono_pulse_h <= 1'b0;
      dev_datao_pulse_h <= 1'b0;
      dev_datai_pulse_h <= 1'b0;
    end else begin
      dmd_m <= ebus_demand_h;
      dmd_s <= dmd_m;
      dmd_s_d <= dmd_s;
      state <= next;
      if (go) begin
        func_r <= ebus_func_h[1:0];
        din_r <= ebus_d_in_h;
      end
      if (go & ebus_func_h[0]) begin
        ebus_d_oe_h <= 1'b1;
        ebus_d_out_h <= ebus_func_h[1] ? dev_data_h : {18'b0, dev_status_h};
      end else if (done) begin
        ebus_d_oe_h <= 1'b0;
        ebus_d_out_h <= '0;
      end
      if ((state == WRITE) & (func_r == 2'd0)) dev_cono_h <= din_r[17:0];
      if ((state == WRITE) & (func_r == 2'd2)) dev_data_h <= din_r;
      else if (dev_load_h) dev_data_h <= dev_load_data_h;
      dev_cono_pulse_h <= (state == WRITE) & (func_r == 2'd0);
      dev_datao_pulse_h <= (state == WRITE) & (func_r == 2'd2);
      dev_datai_pulse_h <= done & (func_r == 2'd3);
    end
  end
endmodule

// File: tb/tb_ebus_dev_responder.sv
// tb_ebus_dev_responder: randomized scoreboard bench for ebus_dev_responder with a register-level reference model
module tb_ebus_dev_responder;
  logic clk_h = 1'b0;
  logic mr_reset_h = 1'b1;
  logic [6:0] ebus_cs_h = '0;
  logic [2:0] ebus_func_h = '0;
  logic ebus_demand_h = 1'b0;
  logic [35:0] ebus_d_in_h = '0;
  logic [35:0] ebus_d_out_h;
  logic ebus_d_oe_h, ebus_xfer_h;
  logic [17:0] dev_status_h = '0;
  logic dev_load_h = 1'b0;
  logic [35:0] dev_load_data_h = '0;
  logic [17:0] dev_cono_h;
  logic [35:0] dev_data_h;
  logic dev_cono_pulse_h, dev_datao_pulse_h, dev_datai_pulse_h;

  ebus_dev_responder #(.DEV_CODE(7'o40)) dut (
    .clk_h(clk_h), .mr_reset_h(mr_reset_h), .ebus_cs_h(ebus_cs_h), .ebus_func_h(ebus_func_h),
    .ebus_demand_h(ebus_demand_h), .ebus_d_in_h(ebus_d_in_h), .ebus_d_out_h(ebus_d_out_h),
    .ebus_d_oe_h(ebus_d_oe_h), .ebus_xfer_h(ebus_xfer_h), .dev_status_h(dev_status_h),
    .dev_load_h(dev_load_h), .dev_load_data_h(dev_load_data_h), .dev_cono_h(dev_cono_h),
    .dev_data_h(dev_data_h), .dev_cono_pulse_h(dev_cono_pulse_h),
    .dev_datao_pulse_h(dev_datao_pulse_h), .dev_datai_pulse_h(dev_datai_pulse_h)
  );

  always #5 clk_h = ~clk_h;

  typedef struct {
    logic [1:0]  func;
    logic [35:0] word;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  logic [17:0] m_cono = '0;
  logic [35:0] m_data = '0;
  int exp_pulse[4] = '{0, 0, 0, 0};
  int got_pulse[4] = '{0, 0, 0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expected response per xfer assertion, checks data for the
  // whole acknowledge window and the bus release when xfer drops.
  exp_t cur;
  bit active = 0;
  logic prev_xfer = 1'b0, prev_oe = 1'b0;
  always @(posedge clk_h) begin
    #2;
    if (dev_cono_pulse_h) got_pulse[0]++;
    if (dev_datao_pulse_h) got_pulse[2]++;
    if (dev_datai_pulse_h) got_pulse[3]++;
    if (ebus_xfer_h && !prev_xfer) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_xfer: got xfer=1 expected no transaction at %0t", $time);
        active = 0;
      end else begin
        cur = q.pop_front();
        active = 1;
        case (cur.func)
          2'd0: begin
            check("cono_reg", dev_cono_h, cur.word);
            check("cono_pulse", dev_cono_pulse_h, 1);
          end
          2'd2: begin
            check("datao_reg", dev_data_h, cur.word);
            check("datao_pulse", dev_datao_pulse_h, 1);
          end
          default: begin
            check("rd_oe_setup", prev_oe, 1);
            check("rd_oe", ebus_d_oe_h, 1);
            check("rd_word", ebus_d_out_h, cur.word);
          end
        endcase
      end
    end else if (ebus_xfer_h && active && cur.func[0]) begin
      check("rd_word_hold", ebus_d_out_h, cur.word);
    end
    if (!ebus_xfer_h && prev_xfer) begin
      check("drop_oe", ebus_d_oe_h, 0);
      check("drop_out", ebus_d_out_h, 0);
      check("datai_pulse_exit", dev_datai_pulse_h, (active && cur.func == 2'd3) ? 1 : 0);
      active = 0;
    end
    prev_xfer = ebus_xfer_h;
    prev_oe = ebus_d_oe_h;
  end

  task automatic expect_hit(input logic [1:0] fn, input logic [35:0] d, input logic [17:0] st);
    case (fn)
      2'd0: begin m_cono = d[17:0]; q.push_back('{func: fn, word: {18'b0, d[17:0]}}); exp_pulse[0]++; end
      2'd1: q.push_back('{func: fn, word: {18'b0, st}});
      2'd2: begin m_data = d; q.push_back('{func: fn, word: d}); exp_pulse[2]++; end
      default: begin q.push_back('{func: fn, word: m_data}); exp_pulse[3]++; end
    endcase
  endtask

  task automatic wait_xfer(input logic lvl, input int limit, output int n);
    n = 0;
    while (ebus_xfer_h !== lvl && n < limit) begin
      @(negedge clk_h);
      n++;
    end
    if (ebus_xfer_h !== lvl) check("xfer_timeout", ebus_xfer_h, lvl);
  endtask

  task automatic txn(input logic [6:0] cs, input logic [2:0] fn, input logic [35:0] d,
                     input logic [17:0] st, input bit collide);
    bit hit, bad;
    int n;
    hit = (cs == 7'o40) && (fn < 3'd4);
    @(negedge clk_h);
    ebus_cs_h = cs;
    ebus_func_h = fn;
    ebus_d_in_h = d;
    dev_status_h = st;
    ebus_demand_h = 1'b1;
    if (hit) begin
      expect_hit(fn[1:0], d, st);
      n = 0;
      while (!ebus_xfer_h && n < 20) begin
        @(negedge clk_h);
        n++;
        dev_load_h = collide && n == 3;
        dev_load_data_h = 36'o1;
      end
      dev_load_h = 1'b0;
      if (!ebus_xfer_h) check("xfer_timeout", ebus_xfer_h, 1);
      else if (!fn[0]) check("write_latency", n, 4);
      if (fn == 3'd1) dev_status_h = ~st;
      repeat ($urandom_range(1, 4)) @(negedge clk_h);
      ebus_demand_h = 1'b0;
      wait_xfer(1'b0, 8, n);
      check("xfer_release", n, 3);
    end else begin
      bad = 0;
      repeat (20) begin
        @(negedge clk_h);
        if (ebus_xfer_h || ebus_d_oe_h) bad = 1;
      end
      check("miss_quiet", bad, 0);
      check("miss_cono", dev_cono_h, m_cono);
      check("miss_data", dev_data_h, m_data);
      ebus_demand_h = 1'b0;
    end
    repeat (3) @(negedge clk_h);
  endtask

  task automatic local_load(input logic [35:0] v);
    @(negedge clk_h);
    dev_load_h = 1'b1;
    dev_load_data_h = v;
    m_data = v;
    @(negedge clk_h);
    dev_load_h = 1'b0;
    @(negedge clk_h);
    check("local_load", dev_data_h, m_data);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_out"}, ebus_d_out_h, 0);
    check({name, "_oe_xfer"}, {ebus_d_oe_h, ebus_xfer_h}, 0);
    check({name, "_cono"}, dev_cono_h, 0);
    check({name, "_data"}, dev_data_h, 0);
    check({name, "_pulses"}, {dev_cono_pulse_h, dev_datao_pulse_h, dev_datai_pulse_h}, 0);
  endtask

  initial begin
    int n;
    logic [35:0] d;
    logic [6:0] cs;
    logic [2:0] fn;
    repeat (3) @(negedge clk_h);
    check_all_zero("reset");
    mr_reset_h = 1'b0;
    repeat (3) @(negedge clk_h);

    txn(7'o40, 3'd0, 36'o000000_123456, 18'o0, 0);
    txn(7'o40, 3'd2, 36'o777000_555111, 18'o0, 0);
    txn(7'o40, 3'd3, 36'o0, 18'o0, 0);
    txn(7'o40, 3'd1, 36'o0, 18'o070707, 0);
    txn(7'o41, 3'd0, 36'o123123_321321, 18'o0, 0);
    txn(7'o40, 3'd5, 36'o654321_123456, 18'o0, 0);
    txn(7'o40, 3'd2, {$urandom, 4'hA}, 18'o0, 1);

    #2 mr_reset_h = 1'b1;
    #1 check_all_zero("async_reset");
    m_cono = '0;
    m_data = '0;
    @(negedge clk_h);
    mr_reset_h = 1'b0;
    repeat (3) @(negedge clk_h);

    // Reset while acknowledging with demand still held: the write replays after release.
    d = {$urandom, 4'h5};
    @(negedge clk_h);
    ebus_cs_h = 7'o40;
    ebus_func_h = 3'd0;
    ebus_d_in_h = d;
    ebus_demand_h = 1'b1;
    expect_hit(2'd0, d, 18'o0);
    wait_xfer(1'b1, 20, n);
    @(negedge clk_h);
    mr_reset_h = 1'b1;
    #1 check("reset_xfer_drop", ebus_xfer_h, 0);
    check("reset_cono_clear", dev_cono_h, 0);
    m_cono = '0;
    expect_hit(2'd0, d, 18'o0);
    @(negedge clk_h);
    mr_reset_h = 1'b0;
    wait_xfer(1'b1, 20, n);
    check("replay_cono", dev_cono_h, m_cono);
    ebus_demand_h = 1'b0;
    wait_xfer(1'b0, 8, n);
    repeat (3) @(negedge clk_h);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) local_load({$urandom, 4'($urandom)});
      cs = ($urandom_range(0, 7) == 0) ? 7'o41 : 7'o40;
      fn = 3'($urandom_range(0, 5));
      txn(cs, fn, {$urandom, 4'($urandom)}, 18'($urandom), fn == 3'd2 && $urandom_range(0, 2) == 0);
    end

    repeat (5) @(negedge clk_h);
    check("cono_pulse_count", got_pulse[0], exp_pulse[0]);
    check("datao_pulse_count", got_pulse[2], exp_pulse[2]);
    check("datai_pulse_count", got_pulse[3], exp_pulse[3]);
    check("queue_drained", q.size(), 0);
    check("final_cono", dev_cono_h, m_cono);
    check("final_data", dev_data_h, m_data);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
